// File: rtl/bus_drive_arbiter.sv
// bus_drive_arbiter: round-robin owner of one shared tri-state bus.
// Drives registered active-low 74S241-style buffer enables (at most one low),
// inserts TURN_CYC dead cycles between owners, and forces an owner off after
// MAX_HOLD cycles when someone else is waiting.
// Optional feature macro: BUS_PARK_EN (park the last owner on the bus when idle).
module bus_drive_arbiter #(
  parameter int NREQ     = 4,
  parameter int OWNW     = 2,
  parameter int MAX_HOLD = 16,
  parameter int TURN_CYC = 1
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] GNT,
  output logic [NREQ-1:0] ENB_N,
  output logic [OWNW-1:0] OWNER,
  output logic            BUSY
);

  localparam logic [7:0]      HOLD_LIM  = 8'(MAX_HOLD - 1);
  localparam logic [3:0]      TURN_LAST = 4'(TURN_CYC - 1);
  localparam logic [OWNW-1:0] LAST_RST  = OWNW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN,
`ifdef BUS_PARK_EN
    S_TURN,
    S_PARK
`else
    S_TURN
`endif
  } state_t;

  state_t          r_state;
  logic [7:0]      r_hold;
  logic [3:0]      r_turn;
  logic [OWNW-1:0] r_last;

  logic            w_any;
  logic [OWNW-1:0] w_win;
  logic [NREQ-1:0] w_win_oh;
  logic            w_own_req;
  logic            w_others;
  logic            w_release;
  int              w_dist;
  int              w_best;

  // Round-robin pick: smallest rotational distance from the slot after r_last.
  always_comb begin
    w_any    = 1'b0;
    w_win    = '0;
    w_win_oh = '0;
    w_dist   = 0;
    w_best   = NREQ;
    for (int j = 0; j < NREQ; j++) begin
      w_dist = (j + 2 * NREQ - 1 - int'(r_last)) % NREQ;
      if (REQ[j] && (w_dist < w_best)) begin
        w_best      = w_dist;
        w_any       = 1'b1;
        w_win       = OWNW'(j);
        w_win_oh    = '0;
        w_win_oh[j] = 1'b1;
      end
    end
  end

  // The low enable bit marks the owner in OWN and PARK, so no index decode is needed.
  assign w_own_req = |(REQ & ~ENB_N);
  assign w_others  = |(REQ & ENB_N);
  assign w_release = !w_own_req || ((r_hold >= HOLD_LIM) && w_others);

  // Ownership FSM; every output is a register written here.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      GNT     <= '0;
      ENB_N   <= '1;
      OWNER   <= '0;
      BUSY    <= 1'b0;
      r_hold  <= '0;
      r_turn  <= '0;
      r_last  <= LAST_RST;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_OWN;
            GNT     <= w_win_oh;
            ENB_N   <= ~w_win_oh;
            OWNER   <= w_win;
            r_last  <= w_win;
            r_hold  <= '0;
            BUSY    <= 1'b1;
          end
        end
        S_OWN: begin
          if (w_release) begin
`ifdef BUS_PARK_EN
            if (!w_own_req && !w_others) begin
              // Nobody else wants the bus: keep it driven by the last owner.
              r_state <= S_PARK;
              GNT     <= '0;
            end else begin
              r_state <= S_TURN;
              GNT     <= '0;
              ENB_N   <= '1;
              r_turn  <= '0;
            end
`else
            r_state <= S_TURN;
            GNT     <= '0;
            ENB_N   <= '1;
            r_turn  <= '0;
`endif
          end else if (r_hold != 8'hFF) begin
            r_hold <= r_hold + 8'd1;
          end
        end
        S_TURN: begin
          if (r_turn == TURN_LAST) begin
            if (w_any) begin
              r_state <= S_OWN;
              GNT     <= w_win_oh;
              ENB_N   <= ~w_win_oh;
              OWNER   <= w_win;
              r_last  <= w_win;
              r_hold  <= '0;
            end else begin
              r_state <= S_IDLE;
              BUSY    <= 1'b0;
            end
          end else begin
            r_turn <= r_turn + 4'd1;
          end
        end
`ifdef BUS_PARK_EN
        S_PARK: begin
          if (w_own_req) begin
            // Parked owner returns with no turnaround; it beats any other requester.
            r_state <= S_OWN;
            GNT     <= ~ENB_N;
            r_hold  <= '0;
          end else if (w_any) begin
            r_state <= S_TURN;
            ENB_N   <= '1;
            r_turn  <= '0;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          GNT     <= '0;
          ENB_N   <= '1;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_drive_arbiter.sv
// Bench for bus_drive_arbiter: directed scenarios plus randomized REQ traffic
// compared each cycle against an ownership model built from the arbitration rules.
module tb_bus_drive_arbiter;
  localparam int N  = 4;
  localparam int MH = 16;
  localparam int TC = 1;
`ifdef BUS_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic [N-1:0] REQ;
  logic [N-1:0] GNT;
  logic [N-1:0] ENB_N;
  logic [1:0]   OWNER;
  logic         BUSY;

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;

  // Model: who owns the bus (-1 none), parked flag, dead cycles left, hold age.
  int m_own, m_gap, m_held, m_last, m_owner_out;
  bit m_park;
  logic [N-1:0] e_gnt, e_enb;
  logic [1:0]   e_own;
  logic         e_busy;

  bus_drive_arbiter #(.NREQ(N), .OWNW(2), .MAX_HOLD(MH), .TURN_CYC(TC)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ),
    .GNT(GNT), .ENB_N(ENB_N), .OWNER(OWNER), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [N-1:0] oth;
    int w;
    if (!RESET_N) begin
      m_own = -1; m_park = 0; m_gap = 0; m_held = 0; m_last = N - 1; m_owner_out = 0;
    end else if (m_own >= 0 && !m_park) begin
      oth = REQ;
      oth[m_own] = 1'b0;
      if (!REQ[m_own]) begin
        if (PARK && oth == '0) m_park = 1;
        else begin m_own = -1; m_gap = TC; end
      end else if (m_held >= MH - 1 && oth != '0) begin
        m_own = -1; m_gap = TC;
      end else if (m_held < 255) begin
        m_held++;
      end
    end else if (m_park) begin
      if (REQ[m_own]) begin m_park = 0; m_held = 0; end
      else if (REQ != '0) begin m_park = 0; m_own = -1; m_gap = TC; end
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      m_gap = 0;
      w = pick(REQ, m_last);
      if (w >= 0) begin m_own = w; m_last = w; m_owner_out = w; m_held = 0; end
    end
    e_gnt = '0;
    e_enb = '1;
    if (m_own >= 0) e_enb[m_own] = 1'b0;
    if (m_own >= 0 && !m_park) e_gnt[m_own] = 1'b1;
    e_own  = m_owner_out[1:0];
    e_busy = (m_own >= 0) || (m_gap > 0);
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    REQ     = '0;
    cyc();
    RESET_N = 1'b1;
  endtask

  // Bus safety: never two drivers, and GNT mirrors the enables outside PARK.
  always @(negedge CLK) begin
    if (mon_en) begin
      vectors++;
      if ($countones(~ENB_N) > 1 || (!m_park && GNT !== ~ENB_N)) begin
        miscompares++;
        $display("FAIL invariant t=%0t: gnt=%b enb_n=%b (need <=1 low, gnt==~enb_n)", $time, GNT, ENB_N);
      end
    end
  end

  task automatic test_reset();
    RESET_N = 1'b0;
    REQ     = '1;
    cyc();
    cyc();
    vectors++;
    if (GNT !== 4'b0000 || ENB_N !== 4'b1111 || OWNER !== 2'd0 || BUSY !== 1'b0 || dut.r_last !== 2'd3) begin
      miscompares++;
      $display("FAIL reset_state: gnt=%b enb=%b own=%0d busy=%b last=%0d, want 0000 1111 0 0 3", GNT, ENB_N, OWNER, BUSY, dut.r_last);
    end
    mon_en  = 1'b1;
    RESET_N = 1'b1;
    cyc();
    vectors++;
    if (GNT !== 4'b0001 || ENB_N !== 4'b1110 || OWNER !== 2'd0 || BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_grant: gnt=%b enb=%b own=%0d busy=%b, want 0001 1110 0 1", GNT, ENB_N, OWNER, BUSY);
    end
  endtask

  task automatic test_single();
    do_reset();
    REQ = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      cyc();
      vectors++;
      if (GNT !== 4'b0010 || ENB_N !== 4'b1101 || OWNER !== 2'd1) begin
        miscompares++;
        $display("FAIL single_own c%0d: gnt=%b enb=%b own=%0d, want 0010 1101 1", i, GNT, ENB_N, OWNER);
      end
    end
    REQ = '0;
    cyc();
    vectors++;
    if (GNT !== 4'b0000 || ENB_N !== 4'b1111 || BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL single_turn: gnt=%b enb=%b busy=%b, want 0000 1111 1", GNT, ENB_N, BUSY);
    end
    cyc();
    vectors++;
    if (GNT !== 4'b0000 || ENB_N !== 4'b1111 || BUSY !== 1'b0 || OWNER !== 2'd1) begin
      miscompares++;
      $display("FAIL single_idle: gnt=%b enb=%b busy=%b own=%0d, want 0000 1111 0 1", GNT, ENB_N, BUSY, OWNER);
    end
  endtask

  task automatic test_hold_rotate();
    logic [N-1:0] xg;
    do_reset();
    REQ = 4'b0101;
    // Each owner gets MH cycles then TC dead cycles; owners alternate 0,2,0.
    for (int t = 0; t < 3 * (MH + TC); t++) begin
      cyc();
      xg = 4'b0000;
      if ((t % (MH + TC)) < MH) xg = (((t / (MH + TC)) % 2) == 1) ? 4'b0100 : 4'b0001;
      vectors++;
      if (GNT !== xg || ENB_N !== ~xg) begin
        miscompares++;
        $display("FAIL hold_rotate t%0d: gnt=%b enb=%b, want gnt=%b enb=%b", t, GNT, ENB_N, xg, ~xg);
      end
    end
    REQ = '0;
    cyc();
    cyc();
  endtask

  task automatic test_saturate();
    do_reset();
    REQ = 4'b1000;
    for (int t = 0; t < 300; t++) begin
      cyc();
      vectors++;
      if (GNT !== 4'b1000 || ENB_N !== 4'b0111) begin
        miscompares++;
        $display("FAIL saturate t%0d: gnt=%b enb=%b, want 1000 0111", t, GNT, ENB_N);
      end
    end
    vectors++;
    if (dut.r_hold !== 8'd255) begin
      miscompares++;
      $display("FAIL saturate_cnt: hold=%0d, want 255", dut.r_hold);
    end
    REQ = '0;
    cyc();
    cyc();
  endtask

  task automatic test_reset_mid();
    do_reset();
    REQ = 4'b0010;
    cyc();
    cyc();
    cyc();
    vectors++;
    if (GNT !== 4'b0010) begin
      miscompares++;
      $display("FAIL rstmid_own: gnt=%b, want 0010", GNT);
    end
    RESET_N = 1'b0;
    cyc();
    vectors++;
    if (GNT !== 4'b0000 || ENB_N !== 4'b1111 || BUSY !== 1'b0 || dut.r_last !== 2'd3) begin
      miscompares++;
      $display("FAIL rstmid_drop: gnt=%b enb=%b busy=%b last=%0d, want 0000 1111 0 3", GNT, ENB_N, BUSY, dut.r_last);
    end
    RESET_N = 1'b1;
    REQ     = '0;
    cyc();
  endtask

`ifdef BUS_PARK_EN
  task automatic test_park();
    do_reset();
    REQ = 4'b0010;
    cyc();
    REQ = '0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      vectors++;
      if (GNT !== 4'b0000 || ENB_N !== 4'b1101 || BUSY !== 1'b1) begin
        miscompares++;
        $display("FAIL park_hold c%0d: gnt=%b enb=%b busy=%b, want 0000 1101 1", i, GNT, ENB_N, BUSY);
      end
    end
    REQ = 4'b0010;
    cyc();
    vectors++;
    if (GNT !== 4'b0010 || ENB_N !== 4'b1101) begin
      miscompares++;
      $display("FAIL park_regrant: gnt=%b enb=%b, want 0010 1101", GNT, ENB_N);
    end
    REQ = 4'b0001;
    cyc();
    vectors++;
    if (GNT !== 4'b0000 || ENB_N !== 4'b1111) begin
      miscompares++;
      $display("FAIL park_turn: gnt=%b enb=%b, want 0000 1111", GNT, ENB_N);
    end
    cyc();
    vectors++;
    if (GNT !== 4'b0001 || ENB_N !== 4'b1110) begin
      miscompares++;
      $display("FAIL park_handoff: gnt=%b enb=%b, want 0001 1110", GNT, ENB_N);
    end
    REQ = '0;
    cyc();
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] r;
    int lim;
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      lim = (c < 1500) ? 7 : 39;
      for (int b = 0; b < N; b++) if ($urandom_range(0, lim) == 0) r[b] = ~r[b];
      REQ     = r;
      RESET_N = ($urandom_range(0, 299) != 0);
      cyc();
      vectors++;
      if (GNT !== e_gnt || ENB_N !== e_enb || OWNER !== e_own || BUSY !== e_busy) begin
        miscompares++;
        $display("FAIL random c%0d req=%b: got gnt=%b enb=%b own=%0d busy=%b, want gnt=%b enb=%b own=%0d busy=%b",
                 c, REQ, GNT, ENB_N, OWNER, BUSY, e_gnt, e_enb, e_own, e_busy);
      end
    end
    RESET_N = 1'b1;
    REQ     = '0;
    cyc();
  endtask

  initial begin
    RESET_N = 1'b0;
    REQ     = '0;
    m_own = -1; m_park = 0; m_gap = 0; m_held = 0; m_last = N - 1; m_owner_out = 0;
    test_reset();
    test_single();
    test_hold_rotate();
    test_saturate();
    test_reset_mid();
`ifdef BUS_PARK_EN
    test_park();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
